// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the imem hold-until-done handshake,
// buffers one response in a skid entry while decode stalls, and squashes on redirect.
module fetch_stage #(
   parameter logic [15:0] RESET_PC    = 16'h0000,
   parameter logic [15:0] NOP_INST    = 16'h0800,
   parameter logic [4:0]  HALT_OPCODE = 5'b00000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        redirect_en,
   input  logic [15:0] redirect_pc,
   output logic        imem_rd,
   output logic [15:0] imem_addr,
   input  logic        imem_done,
   input  logic [15:0] imem_data,
   output logic        if_id_valid,
   output logic [15:0] if_id_pc,
   output logic [15:0] if_id_pc_plus2,
   output logic [15:0] if_id_inst,
   output logic        halted
);

   localparam int unsigned XLEN = 16;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      DROP  = 2'd1,
      HALT  = 2'd2
   } fetchStateE;

   fetchStateE      state;
   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] dropAddr;
   logic            skidValid;
   logic [XLEN-1:0] skidPc;
   logic [XLEN-1:0] skidInst;

   logic            accept;
   logic            isHalt;
   logic [XLEN-1:0] redirectTarget;

   // Request is held while the skid entry is empty; DROP keeps the squashed address on the bus.
   assign imem_rd        = (state == DROP) || ((state == FETCH) && !skidValid);
   assign imem_addr      = (state == DROP) ? dropAddr : pc;
   assign accept         = (state == FETCH) && !skidValid && imem_done && !redirect_en;
   assign isHalt         = (imem_data[15:11] == HALT_OPCODE);
   assign redirectTarget = {redirect_pc[15:1], 1'b0};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state          <= FETCH;
         pc             <= RESET_PC;
         dropAddr       <= RESET_PC;
         skidValid      <= 1'b0;
         skidPc         <= '0;
         skidInst       <= NOP_INST;
         if_id_valid    <= 1'b0;
         if_id_pc       <= '0;
         if_id_pc_plus2 <= XLEN'(2);
         if_id_inst     <= NOP_INST;
         halted         <= 1'b0;
      end else if (redirect_en) begin
         // Redirect overrides stall: flush IF/ID and skid, squash any in-flight request.
         pc          <= redirectTarget;
         halted      <= 1'b0;
         skidValid   <= 1'b0;
         if_id_valid <= 1'b0;
         if_id_inst  <= NOP_INST;
         if (imem_rd && !imem_done) begin
            state    <= DROP;
            dropAddr <= imem_addr;
         end else begin
            state <= FETCH;
         end
      end else begin
         case (state)
            FETCH: begin
               if (accept) begin
                  pc <= pc + XLEN'(2);
                  if (isHalt) begin
                     state  <= HALT;
                     halted <= 1'b1;
                  end
               end
            end
            DROP: begin
               if (imem_done) state <= FETCH;
            end
            HALT: begin
               state <= HALT;
            end
            default: begin
               state <= FETCH;
            end
         endcase

         // IF/ID priority: skid entry, then fresh response, then bubble.
         if (!stall) begin
            if (skidValid) begin
               if_id_valid    <= 1'b1;
               if_id_pc       <= skidPc;
               if_id_pc_plus2 <= skidPc + XLEN'(2);
               if_id_inst     <= skidInst;
               skidValid      <= 1'b0;
            end else if (accept) begin
               if_id_valid    <= 1'b1;
               if_id_pc       <= pc;
               if_id_pc_plus2 <= pc + XLEN'(2);
               if_id_inst     <= imem_data;
            end else begin
               if_id_valid <= 1'b0;
               if_id_inst  <= NOP_INST;
            end
         end else if (accept) begin
            skidValid <= 1'b1;
            skidPc    <= pc;
            skidInst  <= imem_data;
         end
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: scenario tasks with hand-computed IF/ID and imem expectations.
module tb_fetch_stage;

   logic        clk;
   logic        rst;
   logic        stall;
   logic        redirect_en;
   logic [15:0] redirect_pc;
   logic        imem_rd;
   logic [15:0] imem_addr;
   logic        imem_done;
   logic [15:0] imem_data;
   logic        if_id_valid;
   logic [15:0] if_id_pc;
   logic [15:0] if_id_pc_plus2;
   logic [15:0] if_id_inst;
   logic        halted;

   int nChecks;
   int nFails;

   fetch_stage dut (
      .clk            (clk),
      .rst            (rst),
      .stall          (stall),
      .redirect_en    (redirect_en),
      .redirect_pc    (redirect_pc),
      .imem_rd        (imem_rd),
      .imem_addr      (imem_addr),
      .imem_done      (imem_done),
      .imem_data      (imem_data),
      .if_id_valid    (if_id_valid),
      .if_id_pc       (if_id_pc),
      .if_id_pc_plus2 (if_id_pc_plus2),
      .if_id_inst     (if_id_inst),
      .halted         (halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyReset();
      rst         = 1'b0;
      stall       = 1'b0;
      redirect_en = 1'b0;
      redirect_pc = 16'h0000;
      imem_done   = 1'b0;
      imem_data   = 16'h0000;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0; stall = 1'b0; redirect_en = 1'b0; redirect_pc = 16'h0000;
      imem_done = 1'b0; imem_data = 16'h0000;
      repeat (2) @(negedge clk);
      nChecks++; if (if_id_valid !== 1'b0) begin nFails++; $display("FAIL reset_valid: got %b want 0", if_id_valid); end
      nChecks++; if (if_id_inst !== 16'h0800) begin nFails++; $display("FAIL reset_inst: got %h want 0800", if_id_inst); end
      nChecks++; if (if_id_pc !== 16'h0000) begin nFails++; $display("FAIL reset_pc: got %h want 0000", if_id_pc); end
      nChecks++; if (if_id_pc_plus2 !== 16'h0002) begin nFails++; $display("FAIL reset_pc_plus2: got %h want 0002", if_id_pc_plus2); end
      nChecks++; if (halted !== 1'b0) begin nFails++; $display("FAIL reset_halted: got %b want 0", halted); end
      rst = 1'b1;
      #1;
      nChecks++; if (imem_rd !== 1'b1) begin nFails++; $display("FAIL reset_imem_rd: got %b want 1", imem_rd); end
      nChecks++; if (imem_addr !== 16'h0000) begin nFails++; $display("FAIL reset_imem_addr: got %h want 0000", imem_addr); end
   endtask

   task automatic test_same_cycle();
      logic [15:0] expInst;
      logic [15:0] expPc;
      applyReset();
      imem_done = 1'b1;
      for (int k = 0; k < 3; k++) begin
         expInst   = 16'(16'h1111 * (k + 1));
         expPc     = 16'(2 * k);
         imem_data = expInst;
         #1;
         nChecks++; if (imem_addr !== expPc) begin nFails++; $display("FAIL same_addr[%0d]: got %h want %h", k, imem_addr, expPc); end
         tick();
         nChecks++; if (if_id_valid !== 1'b1) begin nFails++; $display("FAIL same_valid[%0d]: got %b want 1", k, if_id_valid); end
         nChecks++; if (if_id_pc !== expPc) begin nFails++; $display("FAIL same_pc[%0d]: got %h want %h", k, if_id_pc, expPc); end
         nChecks++; if (if_id_inst !== expInst) begin nFails++; $display("FAIL same_inst[%0d]: got %h want %h", k, if_id_inst, expInst); end
         nChecks++; if (if_id_pc_plus2 !== 16'(expPc + 16'd2)) begin nFails++; $display("FAIL same_plus2[%0d]: got %h want %h", k, if_id_pc_plus2, 16'(expPc + 16'd2)); end
      end
      imem_done = 1'b0;
      tick();
      nChecks++; if (if_id_valid !== 1'b0) begin nFails++; $display("FAIL same_bubble_valid: got %b want 0", if_id_valid); end
      nChecks++; if (if_id_inst !== 16'h0800) begin nFails++; $display("FAIL same_bubble_inst: got %h want 0800", if_id_inst); end
      nChecks++; if (imem_addr !== 16'h0006) begin nFails++; $display("FAIL same_next_addr: got %h want 0006", imem_addr); end
   endtask

   task automatic test_latency();
      logic [15:0] expInst;
      logic [15:0] expPc;
      applyReset();
      for (int k = 0; k < 2; k++) begin
         expPc   = 16'(2 * k);
         expInst = 16'(16'hA000 + k);
         imem_done = 1'b0;
         for (int w = 0; w < 2; w++) begin
            #1;
            nChecks++; if (imem_rd !== 1'b1 || imem_addr !== expPc) begin nFails++; $display("FAIL lat_wait[%0d.%0d]: rd %b addr %h want rd 1 addr %h", k, w, imem_rd, imem_addr, expPc); end
            tick();
            nChecks++; if (if_id_valid !== 1'b0 || if_id_inst !== 16'h0800) begin nFails++; $display("FAIL lat_bubble[%0d.%0d]: valid %b inst %h want 0 0800", k, w, if_id_valid, if_id_inst); end
         end
         imem_done = 1'b1;
         imem_data = expInst;
         #1;
         nChecks++; if (imem_addr !== expPc) begin nFails++; $display("FAIL lat_done_addr[%0d]: got %h want %h", k, imem_addr, expPc); end
         tick();
         nChecks++; if (if_id_valid !== 1'b1 || if_id_pc !== expPc || if_id_inst !== expInst) begin nFails++; $display("FAIL lat_ifid[%0d]: valid %b pc %h inst %h want 1 %h %h", k, if_id_valid, if_id_pc, if_id_inst, expPc, expInst); end
      end
      imem_done = 1'b0;
   endtask

   task automatic test_stall();
      applyReset();
      imem_done = 1'b1;
      imem_data = 16'h1111; tick();
      imem_data = 16'h2222; tick();
      imem_data = 16'h1234; tick();
      stall = 1'b1; imem_done = 1'b0;
      tick();
      nChecks++; if (if_id_valid !== 1'b1 || if_id_pc !== 16'h0004 || if_id_inst !== 16'h1234) begin nFails++; $display("FAIL stall_hold1: valid %b pc %h inst %h want 1 0004 1234", if_id_valid, if_id_pc, if_id_inst); end
      imem_done = 1'b1; imem_data = 16'h3333;
      #1;
      nChecks++; if (imem_rd !== 1'b1 || imem_addr !== 16'h0006) begin nFails++; $display("FAIL stall_req: rd %b addr %h want 1 0006", imem_rd, imem_addr); end
      tick();
      imem_done = 1'b0;
      #1;
      nChecks++; if (imem_rd !== 1'b0) begin nFails++; $display("FAIL stall_rd_drop: got %b want 0", imem_rd); end
      nChecks++; if (if_id_pc !== 16'h0004 || if_id_inst !== 16'h1234) begin nFails++; $display("FAIL stall_hold2: pc %h inst %h want 0004 1234", if_id_pc, if_id_inst); end
      tick();
      nChecks++; if (imem_rd !== 1'b0 || if_id_inst !== 16'h1234) begin nFails++; $display("FAIL stall_hold3: rd %b inst %h want 0 1234", imem_rd, if_id_inst); end
      stall = 1'b0;
      tick();
      nChecks++; if (if_id_valid !== 1'b1 || if_id_pc !== 16'h0006 || if_id_inst !== 16'h3333 || if_id_pc_plus2 !== 16'h0008) begin nFails++; $display("FAIL stall_release: valid %b pc %h inst %h p2 %h want 1 0006 3333 0008", if_id_valid, if_id_pc, if_id_inst, if_id_pc_plus2); end
      nChecks++; if (imem_rd !== 1'b1 || imem_addr !== 16'h0008) begin nFails++; $display("FAIL stall_resume: rd %b addr %h want 1 0008", imem_rd, imem_addr); end
      imem_done = 1'b1; imem_data = 16'h4444;
      tick();
      nChecks++; if (if_id_pc !== 16'h0008 || if_id_inst !== 16'h4444) begin nFails++; $display("FAIL stall_next: pc %h inst %h want 0008 4444", if_id_pc, if_id_inst); end
      imem_done = 1'b0;
   endtask

   task automatic test_redirect();
      applyReset();
      imem_done = 1'b1; imem_data = 16'h1111;
      tick();
      stall = 1'b1; imem_done = 1'b0;
      tick();
      redirect_en = 1'b1; redirect_pc = 16'h0041;
      tick();
      redirect_en = 1'b0; stall = 1'b0;
      #1;
      nChecks++; if (if_id_valid !== 1'b0 || if_id_inst !== 16'h0800 || if_id_pc !== 16'h0000) begin nFails++; $display("FAIL redir_flush: valid %b inst %h pc %h want 0 0800 0000", if_id_valid, if_id_inst, if_id_pc); end
      nChecks++; if (imem_rd !== 1'b1 || imem_addr !== 16'h0002) begin nFails++; $display("FAIL redir_drop_hold: rd %b addr %h want 1 0002", imem_rd, imem_addr); end
      tick();
      imem_done = 1'b1; imem_data = 16'h5555;
      #1;
      nChecks++; if (imem_addr !== 16'h0002) begin nFails++; $display("FAIL redir_drop_addr: got %h want 0002", imem_addr); end
      tick();
      nChecks++; if (if_id_valid !== 1'b0 || if_id_inst !== 16'h0800) begin nFails++; $display("FAIL redir_discard: valid %b inst %h want 0 0800", if_id_valid, if_id_inst); end
      nChecks++; if (imem_rd !== 1'b1 || imem_addr !== 16'h0040) begin nFails++; $display("FAIL redir_new_addr: rd %b addr %h want 1 0040", imem_rd, imem_addr); end
      imem_data = 16'h6666;
      tick();
      nChecks++; if (if_id_valid !== 1'b1 || if_id_pc !== 16'h0040 || if_id_inst !== 16'h6666 || if_id_pc_plus2 !== 16'h0042) begin nFails++; $display("FAIL redir_first: valid %b pc %h inst %h p2 %h want 1 0040 6666 0042", if_id_valid, if_id_pc, if_id_inst, if_id_pc_plus2); end
      imem_done = 1'b0;
   endtask

   task automatic test_halt();
      applyReset();
      imem_done = 1'b1; imem_data = 16'h1111;
      repeat (5) tick();
      imem_data = 16'h0000;
      tick();
      imem_done = 1'b0;
      #1;
      nChecks++; if (halted !== 1'b1 || imem_rd !== 1'b0) begin nFails++; $display("FAIL halt_assert: halted %b rd %b want 1 0", halted, imem_rd); end
      nChecks++; if (if_id_valid !== 1'b1 || if_id_pc !== 16'h000A || if_id_inst !== 16'h0000) begin nFails++; $display("FAIL halt_ifid: valid %b pc %h inst %h want 1 000a 0000", if_id_valid, if_id_pc, if_id_inst); end
      tick();
      imem_done = 1'b1; imem_data = 16'h9999;
      tick();
      imem_done = 1'b0;
      #1;
      nChecks++; if (halted !== 1'b1 || imem_rd !== 1'b0 || if_id_valid !== 1'b0) begin nFails++; $display("FAIL halt_stray: halted %b rd %b valid %b want 1 0 0", halted, imem_rd, if_id_valid); end
      redirect_en = 1'b1; redirect_pc = 16'h0020;
      tick();
      redirect_en = 1'b0;
      #1;
      nChecks++; if (halted !== 1'b0 || imem_rd !== 1'b1 || imem_addr !== 16'h0020) begin nFails++; $display("FAIL halt_exit: halted %b rd %b addr %h want 0 1 0020", halted, imem_rd, imem_addr); end
      imem_done = 1'b1; imem_data = 16'h7777;
      tick();
      nChecks++; if (if_id_pc !== 16'h0020 || if_id_inst !== 16'h7777) begin nFails++; $display("FAIL halt_resume: pc %h inst %h want 0020 7777", if_id_pc, if_id_inst); end
      imem_done = 1'b0;
   endtask

   task automatic test_wrap_and_reset();
      applyReset();
      imem_done = 1'b1; imem_data = 16'hBEEF;
      redirect_en = 1'b1; redirect_pc = 16'hFFFF;
      tick();
      redirect_en = 1'b0;
      #1;
      nChecks++; if (imem_rd !== 1'b1 || imem_addr !== 16'hFFFE || if_id_valid !== 1'b0) begin nFails++; $display("FAIL wrap_redirect: rd %b addr %h valid %b want 1 fffe 0", imem_rd, imem_addr, if_id_valid); end
      imem_data = 16'h1234;
      tick();
      nChecks++; if (if_id_pc !== 16'hFFFE || if_id_pc_plus2 !== 16'h0000 || if_id_inst !== 16'h1234) begin nFails++; $display("FAIL wrap_ifid: pc %h p2 %h inst %h want fffe 0000 1234", if_id_pc, if_id_pc_plus2, if_id_inst); end
      nChecks++; if (imem_addr !== 16'h0000) begin nFails++; $display("FAIL wrap_addr: got %h want 0000", imem_addr); end
      imem_data = 16'h2222; tick();
      imem_data = 16'h3333; tick();
      stall = 1'b1; imem_done = 1'b0;
      tick();
      nChecks++; if (imem_addr !== 16'h0004 || if_id_pc !== 16'h0002) begin nFails++; $display("FAIL midreq_pre: addr %h pc %h want 0004 0002", imem_addr, if_id_pc); end
      rst = 1'b0;
      #1;
      nChecks++; if (imem_rd !== 1'b1 || imem_addr !== 16'h0000) begin nFails++; $display("FAIL midreq_imem: rd %b addr %h want 1 0000", imem_rd, imem_addr); end
      nChecks++; if (if_id_valid !== 1'b0 || if_id_pc !== 16'h0000 || if_id_pc_plus2 !== 16'h0002 || if_id_inst !== 16'h0800 || halted !== 1'b0) begin nFails++; $display("FAIL midreq_ifid: valid %b pc %h p2 %h inst %h halted %b want 0 0000 0002 0800 0", if_id_valid, if_id_pc, if_id_pc_plus2, if_id_inst, halted); end
      stall = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1;
   endtask

   initial begin
      nChecks     = 0;
      nFails      = 0;
      rst         = 1'b0;
      stall       = 1'b0;
      redirect_en = 1'b0;
      redirect_pc = 16'h0000;
      imem_done   = 1'b0;
      imem_data   = 16'h0000;
      test_reset();
      test_same_cycle();
      test_latency();
      test_stall();
      test_redirect();
      test_halt();
      test_wrap_and_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
